// File: rtl/my_ret_stack.sv
// Return-address stack beside my_pc: push PC+1 on call, pop on return.
// The top entry is always visible on out; push+pop replaces the top (tail call).
module my_ret_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = AW'(count - CW'(1));
    assign out     = empty ? '0 : mem[top_idx];

    // Storage write port: a plain push lands above the top, push+pop overwrites it.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = AW'(count);
        if (!clear && push) begin
            if (pop) begin
                wr_en  = 1'b1;
                wr_idx = empty ? '0 : top_idx;
            end else if (!full) begin
                wr_en  = 1'b1;
                wr_idx = AW'(count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (full) overflow <= 1'b1;
                    else      count    <= count + CW'(1);
                end
                2'b01: begin
                    if (empty) underflow <= 1'b1;
                    else       count     <= count - CW'(1);
                end
                2'b11: begin
                    // Return-then-call on an empty stack still records the bad return.
                    if (empty) begin
                        underflow <= 1'b1;
                        count     <= CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_ret_stack.sv
// Directed bench for my_ret_stack: driver queues expected outputs, a monitor compares them.
module tb_my_ret_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             ov;
        logic             un;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   total = 0;
    int   bad   = 0;

    my_ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .in(in),
        .out(out), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every pending expectation at the falling edge or on demand.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                total++;
                if ({out, count, empty, full, overflow, underflow} !==
                    {r.out, r.count, r.empty, r.full, r.ov, r.un}) begin
                    bad++;
                    $display("FAIL %s: got out=%h count=%0d empty=%b full=%b ov=%b un=%b, expected out=%h count=%0d empty=%b full=%b ov=%b un=%b",
                             r.name, out, count, empty, full, overflow, underflow,
                             r.out, r.count, r.empty, r.full, r.ov, r.un);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [WIDTH-1:0] o, input int c, input logic ov,
                                input logic un, input string nm);
        exp_t e;
        e.out   = o;
        e.count = CW'(c);
        e.empty = (c == 0);
        e.full  = (c == DEPTH);
        e.ov    = ov;
        e.un    = un;
        e.name  = nm;
        return e;
    endfunction

    task automatic cyc(input logic p, input logic q, input logic c, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] eo, input int ecnt, input logic eov,
                       input logic eun, input string nm);
        push  = p;
        pop   = q;
        clear = c;
        in    = d;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(eo, ecnt, eov, eun, nm));
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        in    = '0;
    endtask

    task automatic check_now(input logic [WIDTH-1:0] eo, input int ecnt, input logic eov,
                             input logic eun, input string nm);
        exp_q.push_back(mk(eo, ecnt, eov, eun, nm));
        -> chk_ev;
        #1;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; in = '0;
        #1 reset = 1'b1;
        #1 check_now(16'h0, 0, 0, 0, "reset_async");
        @(negedge clk); #1 reset = 1'b0;
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "reset_idle");

        cyc(1, 0, 0, 16'd1,   16'd1,   1, 0, 0, "push_1");
        cyc(1, 0, 0, 16'd2,   16'd2,   2, 0, 0, "push_2");
        cyc(1, 0, 0, 16'h8285, 16'h8285, 3, 0, 0, "push_neg");
        cyc(0, 1, 0, 16'h0, 16'd2, 2, 0, 0, "pop_to_2");
        cyc(0, 1, 0, 16'h0, 16'd1, 1, 0, 0, "pop_to_1");
        cyc(0, 1, 0, 16'h0, 16'd0, 0, 0, 0, "pop_to_empty");

        for (int i = 0; i < DEPTH; i++)
            cyc(1, 0, 0, WIDTH'(10 + i), WIDTH'(10 + i), i + 1, 0, 0, "fill");
        cyc(1, 0, 0, 16'd99, 16'd17, 8, 1, 0, "push_full_overflow");
        cyc(0, 1, 0, 16'h0,  16'd16, 7, 1, 0, "pop_after_overflow");
        cyc(1, 0, 0, 16'd77, 16'd77, 8, 1, 0, "refill_top");
        cyc(1, 1, 0, 16'd55, 16'd55, 8, 1, 0, "pushpop_full");
        cyc(0, 1, 0, 16'h0,  16'd16, 7, 1, 0, "below_top_intact");

        cyc(0, 0, 1, 16'h0, 16'h0, 0, 0, 0, "clear_flush");
        cyc(0, 1, 0, 16'h0, 16'h0, 0, 0, 1, "pop_empty_underflow");
        cyc(1, 1, 0, 16'd5, 16'd5, 1, 0, 1, "pushpop_empty");
        cyc(1, 0, 1, 16'd9, 16'h0, 0, 0, 0, "clear_beats_push");

        cyc(1, 0, 0, 16'd3,  16'd3,  1, 0, 0, "push_3");
        cyc(1, 0, 0, 16'd7,  16'd7,  2, 0, 0, "push_7");
        cyc(1, 1, 0, 16'd42, 16'd42, 2, 0, 0, "pushpop_replace");
        cyc(0, 1, 0, 16'h0,  16'd3,  1, 0, 0, "pop_after_replace");

        cyc(1, 0, 0, 16'd100, 16'd100, 2, 0, 0, "pre_reset_push_a");
        cyc(1, 0, 0, 16'd101, 16'd101, 3, 0, 0, "pre_reset_push_b");
        cyc(1, 0, 0, 16'd102, 16'd102, 4, 0, 0, "pre_reset_push_c");
        @(negedge clk); #1;
        reset = 1'b1;
        #1 check_now(16'h0, 0, 0, 0, "reset_mid_op");
        cyc(1, 0, 0, 16'd200, 16'h0, 0, 0, 0, "push_during_reset_a");
        push = 1'b1; in = 16'd201;
        cyc(1, 0, 0, 16'd201, 16'h0, 0, 0, 0, "push_during_reset_b");
        @(negedge clk); #1 reset = 1'b0;
        cyc(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "after_reset_idle");
        cyc(1, 0, 0, 16'd6, 16'd6, 1, 0, 0, "after_reset_push");

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
